mem_ctrl: RTL
=============

# mem_ctrl

Request-side controller that initiates accesses into the single-port synchronous `memory` block (1-cycle registered read, write-first). Accepts one read or write at a time from a core over a valid/ready request channel, drives the memory port, and returns read data over a valid/ready response channel. Sits between the sim CPU's load/store path and the `memory` instance.

## Interface
- `ADDR_WIDTH`, 6: memory address width; must match the attached `memory`.
- `DATA_WIDTH`, 16: data word width; must match the attached `memory`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  access address.
- `req_data`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_data`  out  DATA_WIDTH  read data.
- `mem_we`  out  1  to `memory.we`.
- `mem_addr`  out  ADDR_WIDTH  to `memory.addr`.
- `mem_data`  out  DATA_WIDTH  to `memory.data`.
- `mem_out`  in  DATA_WIDTH  from `memory.out`.

## Operation
- States: IDLE, RD_WAIT, RSP.
- IDLE: `req_ready`=1. `mem_addr`=`req_addr` and `mem_data`=`req_data`, driven combinationally.
  - `req_valid`&`req_we`: `mem_we`=1 this cycle. Write is committed at the edge. No response. Stay in IDLE.
  - `req_valid`&!`req_we`: `mem_we`=0. Latch `req_addr` into `addr_q`. Go to RD_WAIT.
  - No request: `mem_we`=0.
- RD_WAIT: `req_ready`=0, `mem_we`=0, `mem_addr`=`addr_q`. `mem_out` now holds the read word. Capture it into `rsp_data`, set `rsp_valid`, go to RSP.
- RSP: `req_ready`=0, `mem_we`=0, `mem_addr`=`addr_q`. `rsp_valid`=1 and `rsp_data` are held stable until `rsp_ready`.
  - On `rsp_ready`: clear `rsp_valid` and go to IDLE.
  - The response is not accepted while `rsp_ready`=0.
- Only one outstanding read. Writes never overlap a pending read.
- Addresses are used modulo 2^ADDR_WIDTH; no range checking.
- `mem_we` is 0 in every non-IDLE state and whenever `rst`=1.

## Timing
- Reset (`rst` high at an edge): state becomes IDLE, `rsp_valid`=0, `rsp_data`=0, `addr_q`=0.
- While `rst`=1: `req_ready`=0 and `mem_we`=0.
- Reset during RD_WAIT or RSP drops the pending read. No response is issued.
- Write: accepted in cycle N and visible to a read accepted in cycle N+1.
- Read: accepted in cycle N, `rsp_valid` high from cycle N+2.
- Read issue rate: minimum 3 cycles per read (N accept, N+2 response handshake, N+3 next accept).
- Write issue rate: back-to-back writes are accepted every cycle.

## Configuration
- `MEM_CTRL_STATS_EN` defined adds output ports `stat_rd` and `stat_wr`, each 16 bits.
  - `stat_rd` counts accepted reads; `stat_wr` counts accepted writes.
  - Both saturate at 16'hFFFF and clear on `rst`.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- `mem_ctrl_pkg` holds the state enum (IDLE/RD_WAIT/RSP) and the stats counter width constant (16).
- One sub-module, `mem_ctrl_stats`: saturating counter pair with increment strobes driven from the accept handshakes. It is instantiated only under `MEM_CTRL_STATS_EN`.
- The `memory` instance is external. The bench connects it alongside the controller.

## Test plan
- Reset then idle: `rst` high for 2 cycles -> `rsp_valid`=0, `rsp_data`=0, `mem_we`=0; `req_ready`=1 on the first cycle after `rst` falls.
- Write/read: write 16'hBEEF to addr 5, then immediately read addr 5 -> `rsp_valid` 2 cycles after read accept with `rsp_data`=16'hBEEF.
- Backpressure: read addr 5 with `rsp_ready`=0 for 4 cycles -> `rsp_valid`/`rsp_data` stable, `req_ready`=0, then IDLE one cycle after `rsp_ready`.
- Address boundary: write 16'h1234 to addr 63, write 16'h5678 to addr 0, read both -> 16'h1234 and 16'h5678 respectively, with no aliasing.
- Reset mid-read: assert `rst` in RD_WAIT -> no `rsp_valid` ever; the next read returns correct data.
- Stats (with `MEM_CTRL_STATS_EN`): 3 writes + 2 reads -> `stat_wr`=3, `stat_rd`=2; preload near saturation -> holds at 16'hFFFF.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl request-side memory controller.
// Holds the FSM state encoding, the statistics counter width and a saturating increment.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RSP     = 2'd2
    } state_e;

    localparam int unsigned STAT_WIDTH = 16;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
        return (&value) ? value : value + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle for mem_ctrl: core request/response channels plus the memory port.
// master = core side, slave = controller, mem = the attached synchronous memory.
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_out;

    modport master (
        output req_valid, req_we, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_data, rsp_ready, mem_out,
        output req_ready, rsp_valid, rsp_data, mem_we, mem_addr, mem_data
    );

    modport mem (
        input  mem_we, mem_addr, mem_data,
        output mem_out
    );

endinterface

// File: rtl/mem_ctrl_stats.sv
// Saturating accepted-read / accepted-write counter pair for mem_ctrl.
// Only instantiated when MEM_CTRL_STATS_EN is defined.
module mem_ctrl_stats
    import mem_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_inc,
    input  logic                  wr_inc,
    output logic [STAT_WIDTH-1:0] stat_rd,
    output logic [STAT_WIDTH-1:0] stat_wr
);

    logic [STAT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [STAT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_inc ? sat_inc(rd_cnt_q) : rd_cnt_q;
        wr_cnt_d = wr_inc ? sat_inc(wr_cnt_q) : wr_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign stat_rd = rd_cnt_q;
    assign stat_wr = wr_cnt_q;

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding request controller in front of a 1-cycle registered-read memory.
// Optional accept counters (stat_rd/stat_wr) are enabled by defining MEM_CTRL_STATS_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_ctrl_if.slave             bus
`ifdef MEM_CTRL_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_rd,
    output logic [STAT_WIDTH-1:0] stat_wr
`endif
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // NOTE: every variable gets a hold-value default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.req_we) begin
                    addr_d  = bus.req_addr;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // The memory registered the read at the accept edge; its output is valid now.
                rsp_data_d  = bus.mem_out;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE) && !rst;
        bus.mem_we    = (state_q == IDLE) && !rst && bus.req_valid && bus.req_we;
        bus.mem_addr  = (state_q == IDLE) ? bus.req_addr : addr_q;
        bus.mem_data  = bus.req_data;
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_data  = rsp_data_q;
    end

`ifdef MEM_CTRL_STATS_EN
    logic rd_accept;
    logic wr_accept;

    assign rd_accept = bus.req_valid && bus.req_ready && !bus.req_we;
    assign wr_accept = bus.req_valid && bus.req_ready && bus.req_we;

    mem_ctrl_stats u_stats (
        .clk     (clk),
        .rst     (rst),
        .rd_inc  (rd_accept),
        .wr_inc  (wr_accept),
        .stat_rd (stat_rd),
        .stat_wr (stat_wr)
    );
`endif

endmodule
